// File: rtl/chain_meas_ctrl.sv
// chain_meas_ctrl: measurement sequencer for the per-bit register delay chains.
// Pulses one selected chain and counts the cycles until the rising edge reaches
// its output (launch latency). It then drops the input and waits for the chain
// to drain again (flush), and reports through a start/busy/done handshake.
// Optional feature macro: CHAIN_MEAS_MISMATCH_EN flags a flush latency that
// differs from the launch latency on the mismatch output.
module chain_meas_ctrl #(
    parameter int NCH     = 8,
    parameter int CW      = 8,
    parameter int TIMEOUT = 255,
    localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [CHW-1:0] ch_sel,
    output logic           busy,
    output logic           done,
    output logic [CW-1:0]  result,
    output logic           timeout,
    output logic           mismatch,
    output logic [NCH-1:0] din_o,
    input  logic [NCH-1:0] dout_i
);

    typedef enum logic [2:0] {
        IDLE,
        PRECLR,
        LAUNCH,
        FLUSH,
        DONE
    } state_t;

    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    state_t         state_q, state_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  result_d;
    logic           timeout_d;
    logic [NCH-1:0] din_d;
    logic           ch_out;
`ifdef CHAIN_MEAS_MISMATCH_EN
    logic           mismatch_d;
`endif

    // Output of the chain under measurement; chains run on clk, so no synchronizer.
    assign ch_out = dout_i[ch_q];

    // Handshake outputs decode straight from the state register.
    assign busy = (state_q == PRECLR) || (state_q == LAUNCH) || (state_q == FLUSH);
    assign done = (state_q == DONE);

    // Next-state, counter and result logic for the measurement sequence.
    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_d    = state_q;
        ch_d       = ch_q;
        cnt_d      = cnt_q;
        result_d   = result;
        timeout_d  = timeout;
        din_d      = '0;
`ifdef CHAIN_MEAS_MISMATCH_EN
        mismatch_d = mismatch;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    ch_d       = ch_sel;
                    cnt_d      = '0;
                    result_d   = '0;
                    timeout_d  = 1'b0;
`ifdef CHAIN_MEAS_MISMATCH_EN
                    mismatch_d = 1'b0;
`endif
                    if (int'(ch_sel) >= NCH) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                    end else begin
                        state_d = PRECLR;
                    end
                end
            end
            PRECLR: begin
                // Drain whatever an interrupted run left in the chain.
                if (!ch_out) begin
                    state_d      = LAUNCH;
                    cnt_d        = '0;
                    din_d[ch_q]  = 1'b1;
                end else if (cnt_q == TMO) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                    result_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LAUNCH: begin
                din_d[ch_q] = 1'b1;
                if (ch_out) begin
                    result_d = cnt_q;
                    state_d  = FLUSH;
                    cnt_d    = '0;
                    din_d    = '0;
                end else if (cnt_q == TMO) begin
                    result_d  = TMO;
                    timeout_d = 1'b1;
                    state_d   = FLUSH;
                    cnt_d     = '0;
                    din_d     = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FLUSH: begin
                if (!ch_out) begin
                    state_d = DONE;
`ifdef CHAIN_MEAS_MISMATCH_EN
                    // Only a clean launch carries a meaningful latency to compare.
                    mismatch_d = !timeout && (cnt_q != result);
`endif
                end else if (cnt_q == TMO) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; async reset drops the chain input without a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            cnt_q    <= '0;
            result   <= '0;
            timeout  <= 1'b0;
            din_o    <= '0;
`ifdef CHAIN_MEAS_MISMATCH_EN
            mismatch <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register updates together on the edge.
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            result   <= result_d;
            timeout  <= timeout_d;
            din_o    <= din_d;
`ifdef CHAIN_MEAS_MISMATCH_EN
            mismatch <= mismatch_d;
`endif
        end
    end

`ifndef CHAIN_MEAS_MISMATCH_EN
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_chain_meas_ctrl.sv
// tb_chain_meas_ctrl: scoreboard bench for chain_meas_ctrl with per-channel
// behavioural chain models (wire, delay chain, stuck-at) and random runs.
module tb_chain_meas_ctrl;

    localparam int NCH     = 8;
    localparam int CW      = 8;
    localparam int TIMEOUT = 255;
    localparam int CHW     = 3;
    localparam int BUDGET  = 1000;

`ifdef CHAIN_MEAS_MISMATCH_EN
    localparam bit MM_EN = 1'b1;
`else
    localparam bit MM_EN = 1'b0;
`endif

    typedef enum int {M_WIRE, M_CHAIN, M_STUCK0, M_STUCK1} mode_t;

    typedef struct packed {
        logic [CW-1:0] r;
        logic          t;
        logic          m;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           start;
    logic [CHW-1:0] ch_sel;
    logic           busy;
    logic           done;
    logic [CW-1:0]  result;
    logic           timeout;
    logic           mismatch;
    logic [NCH-1:0] din_o;
    logic [NCH-1:0] dout_i;

    mode_t cfg_mode [NCH];
    int    rise_d   [NCH];
    int    fall_d   [NCH];

    logic [255:0]   sh [NCH] = '{default: '0};
    logic [NCH-1:0] chain_q = '0;

    exp_t sb[$];
    int   n_pass = 0;
    int   n_total = 0;
    int   n_done = 0;
    int   din_bad_cnt = 0;
    int   din_hit_cnt = 0;
    int   act_ch = 0;
    logic done_prev = 1'b0;

    chain_meas_ctrl #(.NCH(NCH), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .ch_sel   (ch_sel),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .timeout  (timeout),
        .mismatch (mismatch),
        .din_o    (din_o),
        .dout_i   (dout_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Delay-chain model: output rises rise_d edges after the input rose and
    // falls fall_d edges after it fell. Contents survive a DUT reset.
    always @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            logic [255:0] nsh;
            nsh = {sh[i][254:0], din_o[i]};
            sh[i] <= nsh;
            chain_q[i] <= chain_q[i] ? nsh[fall_d[i]-1] : nsh[rise_d[i]-1];
        end
    end

    // Chain outputs seen by the DUT, per channel mode.
    always_comb begin
        dout_i = '0;
        for (int i = 0; i < NCH; i++) begin
            case (cfg_mode[i])
                M_WIRE:   dout_i[i] = din_o[i];
                M_STUCK0: dout_i[i] = 1'b0;
                M_STUCK1: dout_i[i] = 1'b1;
                default:  dout_i[i] = chain_q[i];
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Expected outcome of a measurement from the channel's physical behaviour.
    function automatic exp_t model(input int ch);
        exp_t e;
        e = '0;
        case (cfg_mode[ch])
            M_CHAIN: begin
                e.r = CW'(rise_d[ch]);
                e.m = MM_EN && (rise_d[ch] != fall_d[ch]);
            end
            M_STUCK0: begin
                e.r = CW'(TIMEOUT);
                e.t = 1'b1;
            end
            M_STUCK1: e.t = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    // Monitor: pops the scoreboard on every done pulse and watches din_o.
    always @(negedge clk) begin
        exp_t e;
        logic [NCH-1:0] onehot;
        onehot = NCH'(1) << act_ch;
        if (!rst) begin
            if (din_o != '0 && din_o != onehot) din_bad_cnt++;
            if (din_o == onehot) din_hit_cnt++;
            if (done) begin
                n_done++;
                check("done_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("result", result, e.r);
                    check("timeout", timeout, e.t);
                    check("mismatch", mismatch, e.m);
                end
                check("busy_on_done", busy, 0);
                check("din_on_done", din_o, 0);
                check("done_single", done_prev, 0);
            end
        end
        done_prev = done;
    end

    task automatic recover();
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        repeat (300) @(negedge clk);
    endtask

    task automatic run_one(input int ch, input bit perturb);
        int  d0, b0, h0;
        bit  seen;
        d0 = n_done;
        b0 = din_bad_cnt;
        h0 = din_hit_cnt;
        act_ch = ch;
        @(negedge clk);
        start = 1'b1;
        ch_sel = CHW'(ch);
        sb.push_back(model(ch));
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < BUDGET && !seen; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                start = 1'b0;
            end else if (perturb && busy) begin
                start = 1'($urandom_range(0, 1));
                ch_sel = CHW'($urandom);
            end
        end
        start = 1'b0;
        #1;
        check("done_seen", seen, 1);
        check("done_count", n_done - d0, 1);
        check("din_onehot", din_bad_cnt - b0, 0);
        if (cfg_mode[ch] != M_STUCK1) check("din_launched", (din_hit_cnt - h0) > 0, 1);
        if (!seen) recover();
    endtask

    initial begin
        int d0;
        bit ok;
        rst = 1'b1;
        start = 1'b0;
        ch_sel = '0;
        cfg_mode = '{M_WIRE, M_CHAIN, M_CHAIN, M_CHAIN, M_CHAIN, M_STUCK0, M_CHAIN, M_STUCK1};
        for (int i = 0; i < NCH; i++) begin
            rise_d[i] = 1;
            fall_d[i] = 1;
        end
        rise_d[1] = int'($urandom_range(1, 200)); fall_d[1] = rise_d[1];
        rise_d[2] = int'($urandom_range(1, 200)); fall_d[2] = rise_d[2];
        rise_d[3] = 64;                            fall_d[3] = 64;
        rise_d[4] = int'($urandom_range(1, 40));  fall_d[4] = rise_d[4];
        rise_d[6] = 10;                            fall_d[6] = 12;

        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_timeout", timeout, 0);
        check("rst_mismatch", mismatch, 0);
        check("rst_din", din_o, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 64-flop chain, wire loopback twice back to back, stuck-at-0, asymmetric.
        run_one(3, 1'b0);
        run_one(0, 1'b0);
        run_one(0, 1'b0);
        run_one(5, 1'b0);
        run_one(6, 1'b0);
        run_one(7, 1'b0);

        // start and ch_sel toggled while busy.
        run_one(3, 1'b1);
        run_one(6, 1'b1);

        // start held high re-triggers from IDLE.
        d0 = n_done;
        act_ch = 0;
        @(negedge clk);
        start = 1'b1;
        ch_sel = '0;
        sb.push_back(model(0));
        sb.push_back(model(0));
        for (int c = 0; c < 200 && (n_done - d0) < 2; c++) begin
            @(negedge clk);
            #1;
        end
        start = 1'b0;
        check("held_start_runs", n_done - d0, 2);
        repeat (3) @(negedge clk);
        check("held_start_idle", busy, 0);

        // Reset in the middle of LAUNCH.
        act_ch = 3;
        @(negedge clk);
        start = 1'b1;
        ch_sel = 3'd3;
        sb.push_back(model(3));
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(negedge clk);
            ok = din_o[3];
        end
        check("launch_reached", ok, 1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_din", din_o, 0);
        check("midrst_busy", busy, 0);
        check("midrst_result", result, 0);
        check("midrst_timeout", timeout, 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        run_one(3, 1'b0);

        // Randomized runs over all channels.
        for (int k = 0; k < 30; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_one(int'($urandom_range(0, NCH - 1)), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
